// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch port, data port and single-port RAM signals of mem_arbiter.
// The arbiter uses the slave modport; the requesters/RAM side uses master.
interface mem_arbiter_if;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ready;
    logic [31:0] if_rdata;
    logic        mem_req;
    logic [3:0]  mem_mode;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_align_err;
    logic [3:0]  ram_mode;
    logic [31:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  if_req, if_addr, mem_req, mem_mode, mem_addr, mem_wdata, ram_rdata,
        output if_ready, if_rdata, mem_ready, mem_rdata, mem_align_err, ram_mode, ram_addr, ram_wdata
    );

    modport master (
        output if_req, if_addr, mem_req, mem_mode, mem_addr, mem_wdata, ram_rdata,
        input  if_ready, if_rdata, mem_ready, mem_rdata, mem_align_err, ram_mode, ram_addr, ram_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port RAM between instruction fetch and data access, data first.
// Define MEM_ALIGN_CHECK_EN to reject misaligned data accesses before they reach the RAM.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 0
) (
    input logic          clk,
    input logic          rst_n,
    mem_arbiter_if.slave bus
);
    localparam logic [3:0] IO_NOP = 4'd0, IO_LW = 4'd5, IO_SB = 4'd6, IO_SH = 4'd7, IO_SW = 4'd8;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, ACC_IF, ACC_MEM} state_t;

    state_t      r_state, w_state;
    logic [3:0]  r_cnt, w_cnt, r_mode, w_mode;
    logic [31:0] r_addr, w_addr, r_wdata, w_wdata;
    logic [31:0] r_if_rdata, w_if_rdata, r_mem_rdata, w_mem_rdata;
    logic        r_if_ready, w_if_ready, r_mem_ready, w_mem_ready, r_align_err, w_align_err;
    logic        w_reject, w_store;

`ifdef MEM_ALIGN_CHECK_EN
    localparam logic [3:0] IO_LH = 4'd3, IO_LHU = 4'd4;
    assign w_reject = ((bus.mem_mode == IO_LW || bus.mem_mode == IO_SW) && bus.mem_addr[1:0] != 2'b00) ||
                      ((bus.mem_mode == IO_LH || bus.mem_mode == IO_LHU || bus.mem_mode == IO_SH) && bus.mem_addr[0]);
`else
    assign w_reject = 1'b0;
`endif

    assign w_store = (r_mode == IO_SB) || (r_mode == IO_SH) || (r_mode == IO_SW);

    // Requester inputs are only looked at in IDLE; the access itself runs from the latched copy.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_mode      = r_mode;
        w_addr      = r_addr;
        w_wdata     = r_wdata;
        w_if_ready  = 1'b0;
        w_if_rdata  = r_if_rdata;
        w_mem_ready = 1'b0;
        w_mem_rdata = r_mem_rdata;
        w_align_err = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.mem_req && w_reject) begin
                    w_mem_ready = 1'b1;
                    w_align_err = 1'b1;
                    w_mem_rdata = '0;
                end else if (bus.mem_req) begin
                    w_state = ACC_MEM;
                    w_cnt   = WAIT_LD;
                    w_mode  = bus.mem_mode;
                    w_addr  = bus.mem_addr;
                    w_wdata = bus.mem_wdata;
                end else if (bus.if_req) begin
                    w_state = ACC_IF;
                    w_cnt   = WAIT_LD;
                    w_mode  = IO_LW;
                    w_addr  = bus.if_addr;
                end
            end
            ACC_IF: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_if_rdata = bus.ram_rdata;
                    w_if_ready = 1'b1;
                    w_state    = IDLE;
                end
            end
            ACC_MEM: begin
                if (r_cnt != 4'd0) begin
                    w_cnt = r_cnt - 4'd1;
                end else begin
                    w_mem_rdata = w_store ? '0 : bus.ram_rdata;
                    w_mem_ready = 1'b1;
                    w_state     = IDLE;
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_mode      <= IO_NOP;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_if_ready  <= 1'b0;
            r_if_rdata  <= '0;
            r_mem_ready <= 1'b0;
            r_mem_rdata <= '0;
            r_align_err <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_mode      <= w_mode;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_if_ready  <= w_if_ready;
            r_if_rdata  <= w_if_rdata;
            r_mem_ready <= w_mem_ready;
            r_mem_rdata <= w_mem_rdata;
            r_align_err <= w_align_err;
        end
    end

    assign bus.ram_mode      = (r_state == IDLE) ? IO_NOP : r_mode;
    assign bus.ram_addr      = r_addr;
    assign bus.ram_wdata     = r_wdata;
    assign bus.if_ready      = r_if_ready;
    assign bus.if_rdata      = r_if_rdata;
    assign bus.mem_ready     = r_mem_ready;
    assign bus.mem_rdata     = r_mem_rdata;
    assign bus.mem_align_err = r_align_err;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench with two arbiters (WAIT_CYCLES 0 and 3), each backed by a
// byte-addressable RAM model that performs load extension and store merging.
module tb_mem_arbiter;
    localparam logic [3:0] IO_NOP = 4'd0, IO_LB = 4'd1, IO_LBU = 4'd2, IO_LH = 4'd3, IO_LHU = 4'd4,
                           IO_LW = 4'd5, IO_SB = 4'd6, IO_SH = 4'd7, IO_SW = 4'd8;

    typedef struct {bit is_mem; logic [31:0] data; logic err;} exp_t;
    typedef struct {
        bit ok; int cyc; bit is_mem; logic [31:0] data; logic err;
        int act; bit stable; bit both; logic [3:0] md; logic [31:0] ad;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        t_if_req[2], t_mem_req[2];
    logic [31:0] t_if_addr[2], t_mem_addr[2], t_mem_wdata[2];
    logic [3:0]  t_mem_mode[2];
    logic        o_if_ready[2], o_mem_ready[2], o_err[2];
    logic [31:0] o_if_rdata[2], o_mem_rdata[2], o_ram_addr[2], o_ram_wdata[2];
    logic [3:0]  o_ram_mode[2];
    logic [31:0] ram[2][256];

    exp_t sb[$];
    int n_vec = 0;
    int n_err = 0;

    function automatic logic [31:0] ram_read(logic [31:0] w, logic [3:0] m, logic [1:0] a);
        logic [7:0]  by;
        logic [15:0] h;
        by = 8'(w >> {a, 3'b000});
        h  = 16'(w >> {a[1], 4'b0000});
        case (m)
            IO_LB:   return {{24{by[7]}}, by};
            IO_LBU:  return {24'd0, by};
            IO_LH:   return {{16{h[15]}}, h};
            IO_LHU:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ram_write(logic [31:0] w, logic [3:0] m, logic [1:0] a, logic [31:0] d);
        logic [31:0] mb, mh;
        mb = 32'hFF << {a, 3'b000};
        mh = 32'hFFFF << {a[1], 4'b0000};
        case (m)
            IO_SB:   return (w & ~mb) | ((d & 32'hFF) << {a, 3'b000});
            IO_SH:   return (w & ~mh) | ((d & 32'hFFFF) << {a[1], 4'b0000});
            IO_SW:   return d;
            default: return w;
        endcase
    endfunction

    for (genvar g = 0; g < 2; g++) begin : u
        mem_arbiter_if b ();
        mem_arbiter #(.WAIT_CYCLES(3 * g)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
        assign b.if_req       = t_if_req[g];
        assign b.if_addr      = t_if_addr[g];
        assign b.mem_req      = t_mem_req[g];
        assign b.mem_mode     = t_mem_mode[g];
        assign b.mem_addr     = t_mem_addr[g];
        assign b.mem_wdata    = t_mem_wdata[g];
        assign b.ram_rdata    = ram_read(ram[g][b.ram_addr[9:2]], b.ram_mode, b.ram_addr[1:0]);
        assign o_if_ready[g]  = b.if_ready;
        assign o_if_rdata[g]  = b.if_rdata;
        assign o_mem_ready[g] = b.mem_ready;
        assign o_mem_rdata[g] = b.mem_rdata;
        assign o_err[g]       = b.mem_align_err;
        assign o_ram_mode[g]  = b.ram_mode;
        assign o_ram_addr[g]  = b.ram_addr;
        assign o_ram_wdata[g] = b.ram_wdata;
    end

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++)
            if (o_ram_mode[k] == IO_SB || o_ram_mode[k] == IO_SH || o_ram_mode[k] == IO_SW)
                ram[k][o_ram_addr[k][9:2]] <= ram_write(ram[k][o_ram_addr[k][9:2]], o_ram_mode[k],
                                                        o_ram_addr[k][1:0], o_ram_wdata[k]);
    end

    // Observes one instance until a ready pulse (bounded), recording RAM-side activity meanwhile.
    task automatic await_ready(input int g, output obs_t o);
        o = '{ok: 0, cyc: 0, is_mem: 0, data: '0, err: 0, act: 0, stable: 1, both: 0, md: IO_NOP, ad: '0};
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (o_ram_mode[g] !== IO_NOP) begin
                if (o.act == 0) begin
                    o.md = o_ram_mode[g];
                    o.ad = o_ram_addr[g];
                end else if (o_ram_mode[g] !== o.md || o_ram_addr[g] !== o.ad) begin
                    o.stable = 0;
                end
                o.act++;
            end
            if (o_if_ready[g] === 1'b1 && o_mem_ready[g] === 1'b1) o.both = 1;
            if (o_if_ready[g] === 1'b1 || o_mem_ready[g] === 1'b1) begin
                o.ok     = 1;
                o.cyc    = c;
                o.is_mem = o_mem_ready[g];
                o.data   = o_mem_ready[g] ? o_mem_rdata[g] : o_if_rdata[g];
                o.err    = o_err[g];
                break;
            end
        end
    endtask

    function automatic exp_t sb_pop();
        exp_t e;
        e = '{is_mem: 0, data: 32'hBAD0BAD0, err: 1'bx};
        if (sb.size() != 0) e = sb.pop_front();
        return e;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            n_vec++;
            if ({o_if_ready[g], o_mem_ready[g], o_err[g], o_if_rdata[g], o_mem_rdata[g],
                 o_ram_addr[g], o_ram_wdata[g], o_ram_mode[g]} !== '0)
                begin n_err++; $display("FAIL reset_state[%0d]: got rdy=%b/%b err=%b ifd=%h md=%h ra=%h rw=%h mode=%h want all 0",
                    g, o_if_ready[g], o_mem_ready[g], o_err[g], o_if_rdata[g], o_mem_rdata[g], o_ram_addr[g], o_ram_wdata[g], o_ram_mode[g]); end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        obs_t o;
        exp_t e;
        sb.push_back('{is_mem: 0, data: 32'h12345678, err: 1'b0});
        t_if_addr[0] = 32'h100;
        t_if_req[0]  = 1'b1;
        await_ready(0, o);
        t_if_req[0] = 1'b0;
        e = sb_pop();
        n_vec++;
        if (!o.ok || o.cyc != 2) begin n_err++; $display("FAIL fetch_latency: got ok=%0d cyc=%0d want cyc=2", o.ok, o.cyc); end
        n_vec++;
        if ({o.is_mem, o.data, o.err} !== {e.is_mem, e.data, e.err})
            begin n_err++; $display("FAIL fetch_data: got mem=%0d %h err=%b want mem=%0d %h err=%b", o.is_mem, o.data, o.err, e.is_mem, e.data, e.err); end
        n_vec++;
        if (o.act != 1 || o.md !== IO_LW || o.ad !== 32'h100)
            begin n_err++; $display("FAIL fetch_ram: got act=%0d mode=%h addr=%h want act=1 mode=%h addr=100", o.act, o.md, o.ad, IO_LW); end
    endtask

    task automatic test_priority();
        obs_t o;
        exp_t e;
        sb.push_back('{is_mem: 1, data: 32'h0, err: 1'b0});
        sb.push_back('{is_mem: 0, data: 32'h12345678, err: 1'b0});
        t_if_addr[0] = 32'h100;
        t_if_req[0]  = 1'b1;
        t_mem_mode[0] = IO_SW;
        t_mem_addr[0] = 32'h200;
        t_mem_wdata[0] = 32'hDEADBEEF;
        t_mem_req[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            await_ready(0, o);
            if (o.is_mem) t_mem_req[0] = 1'b0;
            else t_if_req[0] = 1'b0;
            e = sb_pop();
            n_vec++;
            if (!o.ok || o.cyc != 2 || {o.is_mem, o.data, o.err} !== {e.is_mem, e.data, e.err} || o.both)
                begin n_err++; $display("FAIL priority[%0d]: got ok=%0d cyc=%0d mem=%0d %h err=%b both=%0d want cyc=2 mem=%0d %h err=%b both=0",
                    i, o.ok, o.cyc, o.is_mem, o.data, o.err, o.both, e.is_mem, e.data, e.err); end
        end
        n_vec++;
        if (ram[0][8'h80] !== 32'hDEADBEEF) begin n_err++; $display("FAIL store_word: got %h want deadbeef", ram[0][8'h80]); end
        sb.push_back('{is_mem: 1, data: 32'hDEADBEEF, err: 1'b0});
        t_mem_mode[0] = IO_LW;
        t_mem_req[0]  = 1'b1;
        await_ready(0, o);
        t_mem_req[0] = 1'b0;
        e = sb_pop();
        n_vec++;
        if (!o.ok || o.cyc != 2 || {o.is_mem, o.data, o.err} !== {e.is_mem, e.data, e.err})
            begin n_err++; $display("FAIL load_after_store: got ok=%0d cyc=%0d mem=%0d %h want cyc=2 mem=1 %h", o.ok, o.cyc, o.is_mem, o.data, e.data); end
    endtask

    task automatic test_back_to_back();
        obs_t o;
        exp_t e;
        ram[0][8'h41] <= 32'hCAFEF00D;
        sb.push_back('{is_mem: 0, data: 32'h12345678, err: 1'b0});
        sb.push_back('{is_mem: 0, data: 32'hCAFEF00D, err: 1'b0});
        t_if_addr[0] = 32'h100;
        t_if_req[0]  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            await_ready(0, o);
            t_if_addr[0] = 32'h104;
            if (i == 1) t_if_req[0] = 1'b0;
            e = sb_pop();
            n_vec++;
            if (!o.ok || o.cyc != 2 || {o.is_mem, o.data} !== {e.is_mem, e.data})
                begin n_err++; $display("FAIL back_to_back[%0d]: got ok=%0d cyc=%0d mem=%0d %h want cyc=2 mem=0 %h", i, o.ok, o.cyc, o.is_mem, o.data, e.data); end
        end
    endtask

    task automatic test_wait_cycles();
        logic [3:0]  modes[8] = '{IO_LB, IO_LBU, IO_LH, IO_LHU, IO_SB, IO_SH, IO_LW, IO_LW};
        logic [31:0] addrs[8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h201, 32'h202, 32'h200, 32'h100};
        logic [31:0] wdats[8] = '{0, 0, 0, 0, 32'hAB, 32'h1234, 0, 0};
        logic [31:0] exps[8]  = '{32'hFFFFFF80, 32'h80, 32'hFFFF8000, 32'h8000, 0, 0, 32'h1234AB00, 32'h80000000};
        obs_t o;
        exp_t e;
        ram[1][8'h40] <= 32'h80000000;
        ram[1][8'h80] <= 32'h0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            sb.push_back('{is_mem: 1, data: exps[i], err: 1'b0});
            t_mem_mode[1]  = modes[i];
            t_mem_addr[1]  = addrs[i];
            t_mem_wdata[1] = wdats[i];
            t_mem_req[1]   = 1'b1;
            await_ready(1, o);
            t_mem_req[1] = 1'b0;
            e = sb_pop();
            n_vec++;
            if (!o.ok || o.cyc != 5 || {o.is_mem, o.data, o.err} !== {e.is_mem, e.data, e.err})
                begin n_err++; $display("FAIL wait_access[%0d]: got ok=%0d cyc=%0d mem=%0d %h err=%b want cyc=5 mem=1 %h err=0",
                    i, o.ok, o.cyc, o.is_mem, o.data, o.err, e.data); end
            n_vec++;
            if (o.act != 4 || !o.stable || o.md !== modes[i] || o.ad !== addrs[i])
                begin n_err++; $display("FAIL wait_ram[%0d]: got act=%0d stable=%0d mode=%h addr=%h want act=4 stable=1 mode=%h addr=%h",
                    i, o.act, o.stable, o.md, o.ad, modes[i], addrs[i]); end
        end
    endtask

    task automatic test_reset_abort();
        obs_t o;
        exp_t e;
        bit seen;
        t_mem_mode[1] = IO_LW;
        t_mem_addr[1] = 32'h100;
        t_mem_req[1]  = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        t_mem_req[1] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        n_vec++;
        if ({o_if_ready[1], o_mem_ready[1], o_err[1], o_if_rdata[1], o_mem_rdata[1],
             o_ram_addr[1], o_ram_wdata[1], o_ram_mode[1]} !== '0)
            begin n_err++; $display("FAIL abort_state: got rdy=%b/%b md=%h ra=%h mode=%h want all 0",
                o_if_ready[1], o_mem_ready[1], o_mem_rdata[1], o_ram_addr[1], o_ram_mode[1]); end
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (o_mem_ready[1] !== 1'b0 || o_ram_mode[1] !== IO_NOP) seen = 1;
        end
        n_vec++;
        if (seen) begin n_err++; $display("FAIL abort_no_ready: got activity=1 want 0"); end
        sb.push_back('{is_mem: 1, data: 32'h80000000, err: 1'b0});
        t_mem_req[1] = 1'b1;
        await_ready(1, o);
        t_mem_req[1] = 1'b0;
        e = sb_pop();
        n_vec++;
        if (!o.ok || o.cyc != 5 || {o.is_mem, o.data} !== {e.is_mem, e.data})
            begin n_err++; $display("FAIL abort_retry: got ok=%0d cyc=%0d mem=%0d %h want cyc=5 mem=1 %h", o.ok, o.cyc, o.is_mem, o.data, e.data); end
    endtask

    task automatic test_align();
        obs_t o;
        exp_t e;
        int want_cyc, want_act;
`ifdef MEM_ALIGN_CHECK_EN
        sb.push_back('{is_mem: 1, data: 32'h0, err: 1'b1});
        want_cyc = 1;
        want_act = 0;
`else
        sb.push_back('{is_mem: 1, data: 32'hDEADBEEF, err: 1'b0});
        want_cyc = 2;
        want_act = 1;
`endif
        t_mem_mode[0] = IO_LW;
        t_mem_addr[0] = 32'h202;
        t_mem_req[0]  = 1'b1;
        await_ready(0, o);
        t_mem_req[0] = 1'b0;
        e = sb_pop();
        n_vec++;
        if (!o.ok || o.cyc != want_cyc || {o.is_mem, o.data, o.err} !== {e.is_mem, e.data, e.err})
            begin n_err++; $display("FAIL align_resp: got ok=%0d cyc=%0d mem=%0d %h err=%b want cyc=%0d mem=1 %h err=%b",
                o.ok, o.cyc, o.is_mem, o.data, o.err, want_cyc, e.data, e.err); end
        n_vec++;
        if (o.act != want_act) begin n_err++; $display("FAIL align_ram: got act=%0d want %0d", o.act, want_act); end
        @(negedge clk);
        n_vec++;
        if (o_mem_ready[0] !== 1'b0 || o_err[0] !== 1'b0)
            begin n_err++; $display("FAIL align_pulse: got rdy=%b err=%b want 0 0", o_mem_ready[0], o_err[0]); end
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 256; a++) ram[k][a] <= 32'h0;
            t_if_req[k]    = 1'b0;
            t_mem_req[k]   = 1'b0;
            t_if_addr[k]   = '0;
            t_mem_addr[k]  = '0;
            t_mem_wdata[k] = '0;
            t_mem_mode[k]  = IO_NOP;
        end
        ram[0][8'h40] <= 32'h12345678;
        test_reset();
        test_fetch();
        test_priority();
        test_back_to_back();
        test_wait_cycles();
        test_reset_abort();
        test_align();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
